// File: rtl/axi_lite_sram_slv.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_lite_sram_slv
//
// AXI-Lite responder for the core's data-side memory port. Read and write
// requests are served from an internal word-addressed SRAM. R and B responses
// come back after a programmable latency.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high. A valid, once raised, holds its
// payload until that edge. Every ready output comes straight from registered
// state, so no valid input reaches a ready output combinationally.
//
// Optional feature: define YSYX_23060251_AXI_RAND_DELAY_EN to add an 8-bit
// LFSR. It adds 0..7 extra cycles to each read and write latency and can drop
// the idle readies (backpressure). With the macro undefined the latencies are
// exactly RD_LAT / WR_LAT and the idle readies stay high.
//
// Parameters
//   BASE_ADDR  byte address of word 0
//   DEPTH      number of 32-bit words (power of two)
//   RD_LAT     extra cycles between AR handshake and r_valid (0..15)
//   WR_LAT     extra cycles between AW+W capture and b_valid (0..15)
//
// Ports
//   clk_i, rst_ni                      clock; async active-low reset
//   slv_ar_valid/addr/ready            read address channel
//   slv_r_valid/data/resp/ready        read data channel
//   slv_aw_valid/addr/ready            write address channel
//   slv_w_valid/data/strb/ready        write data channel
//   slv_b_valid/resp/ready             write response channel
//   dbg_r_state_o, dbg_w_state_o       current read / write FSM state
//
// Response encoding (axi_resp_t): 2'b00 OKAY, 2'b10 SLVERR.
// ---------------------------------------------------------------------------
module axi_lite_sram_slv #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned WR_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // read address
    input  logic        slv_ar_valid_i,
    input  logic [31:0] slv_ar_addr_i,
    output logic        slv_ar_ready_o,
    // read data
    output logic        slv_r_valid_o,
    output logic [31:0] slv_r_data_o,
    output logic [1:0]  slv_r_resp_o,
    input  logic        slv_r_ready_i,
    // write address
    input  logic        slv_aw_valid_i,
    input  logic [31:0] slv_aw_addr_i,
    output logic        slv_aw_ready_o,
    // write data
    input  logic        slv_w_valid_i,
    input  logic [31:0] slv_w_data_i,
    input  logic [3:0]  slv_w_strb_i,
    output logic        slv_w_ready_o,
    // write response
    output logic        slv_b_valid_o,
    output logic [1:0]  slv_b_resp_o,
    input  logic        slv_b_ready_i,
    // debug visibility of both FSMs
    output logic [1:0]  dbg_r_state_o,
    output logic [1:0]  dbg_w_state_o
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [31:0] mem [DEPTH];

    // -----------------------------------------------------------------------
    // Optional random delay / backpressure source
    // -----------------------------------------------------------------------
    logic [2:0] extra;
    logic       stall;

`ifdef YSYX_23060251_AXI_RAND_DELAY_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = lfsr[2:0];
    assign stall = lfsr[7];
`else
    assign extra = 3'd0;
    assign stall = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [4:0]       r_cnt;
    logic [4:0]       r_tgt;
    logic [31:0]      ar_addr_q;
    logic [31:0]      r_data;
    logic [1:0]       r_resp;

    logic             ar_ready_int;
    logic             ar_fire;
    logic [4:0]       rd_tgt_new;
    logic             rd_load;
    logic [31:0]      rd_addr_cur;
    logic [31:0]      rd_off;
    logic             rd_ok;
    logic [IDX_W-1:0] rd_idx;

    assign ar_ready_int = (r_state == R_IDLE) && !stall;
    assign ar_fire      = slv_ar_valid_i && ar_ready_int;
    assign rd_tgt_new   = 5'(RD_LAT) + {2'b00, extra};

    // With zero total latency the word is fetched on the AR handshake edge
    // itself, so the live bus address is used while still idle.
    assign rd_addr_cur = (r_state == R_IDLE) ? slv_ar_addr_i : ar_addr_q;
    assign rd_off      = rd_addr_cur - BASE_ADDR;
    assign rd_ok       = (rd_off < SPAN);
    assign rd_idx      = rd_off[IDX_W+1:2];

    // Edge that enters R_RESP. The array read here sees the value before any
    // write landing on the same edge.
    assign rd_load = (ar_fire && (rd_tgt_new == 5'd0)) ||
                     ((r_state == R_WAIT) && (r_cnt == r_tgt));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= R_IDLE;
            r_cnt     <= 5'd0;
            r_tgt     <= 5'd0;
            ar_addr_q <= 32'h0;
            r_data    <= 32'h0;
            r_resp    <= RESP_OKAY;
        end else begin
            if (rd_load) begin
                r_data <= rd_ok ? mem[rd_idx] : 32'h0;
                r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        ar_addr_q <= slv_ar_addr_i;
                        r_tgt     <= rd_tgt_new;
                        if (rd_tgt_new == 5'd0) begin
                            r_state <= R_RESP;
                        end else begin
                            r_state <= R_WAIT;
                            r_cnt   <= 5'd1;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt == r_tgt) begin
                        r_state <= R_RESP;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                R_RESP: begin
                    if (slv_r_ready_i) begin
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    logic [1:0]       w_state;
    logic [4:0]       w_cnt;
    logic [4:0]       w_tgt;
    logic             aw_done;
    logic             w_done;
    logic [31:0]      aw_addr_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic [1:0]       b_resp;

    logic             aw_ready_int;
    logic             w_ready_int;
    logic             aw_fire;
    logic             w_fire;
    logic             wr_accept;
    logic [4:0]       wr_tgt_new;
    logic             wr_commit;
    logic [31:0]      wr_addr_cur;
    logic [31:0]      wr_data_cur;
    logic [3:0]       wr_strb_cur;
    logic [31:0]      wr_off;
    logic             wr_ok;
    logic [IDX_W-1:0] wr_idx;

    // AW and W are captured independently. Each ready drops once its own
    // half is held and stays low until the B handshake.
    assign aw_ready_int = (w_state == W_IDLE) && !aw_done && !stall;
    assign w_ready_int  = (w_state == W_IDLE) && !w_done && !stall;
    assign aw_fire      = slv_aw_valid_i && aw_ready_int;
    assign w_fire       = slv_w_valid_i && w_ready_int;

    // The request is accepted on the edge where the second half arrives (or
    // both arrive together).
    assign wr_accept  = (w_state == W_IDLE) &&
                        (aw_done || aw_fire) && (w_done || w_fire);
    assign wr_tgt_new = 5'(WR_LAT) + {2'b00, extra};

    // A half not yet latched is taken from the bus; this only matters when
    // the commit coincides with acceptance (zero total latency).
    assign wr_addr_cur = aw_done ? aw_addr_q : slv_aw_addr_i;
    assign wr_data_cur = w_done ? w_data_q : slv_w_data_i;
    assign wr_strb_cur = w_done ? w_strb_q : slv_w_strb_i;
    assign wr_off      = wr_addr_cur - BASE_ADDR;
    assign wr_ok       = (wr_off < SPAN);
    assign wr_idx      = wr_off[IDX_W+1:2];

    // Edge that enters W_RESP: the array is updated here. A reset during
    // W_WAIT returns the FSM to idle before this edge, so nothing commits.
    assign wr_commit = (wr_accept && (wr_tgt_new == 5'd0)) ||
                       ((w_state == W_WAIT) && (w_cnt == w_tgt));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state   <= W_IDLE;
            w_cnt     <= 5'd0;
            w_tgt     <= 5'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            aw_addr_q <= 32'h0;
            w_data_q  <= 32'h0;
            w_strb_q  <= 4'h0;
            b_resp    <= RESP_OKAY;
        end else begin
            if (aw_fire) begin
                aw_addr_q <= slv_aw_addr_i;
                aw_done   <= 1'b1;
            end
            if (w_fire) begin
                w_data_q <= slv_w_data_i;
                w_strb_q <= slv_w_strb_i;
                w_done   <= 1'b1;
            end
            if (wr_commit) begin
                b_resp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            case (w_state)
                W_IDLE: begin
                    if (wr_accept) begin
                        w_tgt <= wr_tgt_new;
                        if (wr_tgt_new == 5'd0) begin
                            w_state <= W_RESP;
                        end else begin
                            w_state <= W_WAIT;
                            w_cnt   <= 5'd1;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt == w_tgt) begin
                        w_state <= W_RESP;
                        w_cnt   <= 5'd0;
                    end else begin
                        w_cnt <= w_cnt + 5'd1;
                    end
                end
                W_RESP: begin
                    if (slv_b_ready_i) begin
                        w_state <= W_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // SRAM array: no reset, byte-granular write enables.
    always_ff @(posedge clk_i) begin
        if (wr_commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb_cur[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data_cur[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign slv_ar_ready_o = ar_ready_int;
    assign slv_r_valid_o  = (r_state == R_RESP);
    assign slv_r_data_o   = r_data;
    assign slv_r_resp_o   = r_resp;

    assign slv_aw_ready_o = aw_ready_int;
    assign slv_w_ready_o  = w_ready_int;
    assign slv_b_valid_o  = (w_state == W_RESP);
    assign slv_b_resp_o   = b_resp;

    assign dbg_r_state_o  = r_state;
    assign dbg_w_state_o  = w_state;

endmodule
